regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: DATA_W, default 64, register and data-port width.
REQ-002 Parameter: NREGS, default 32, register count; address width is 5 bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 we3  input  1  write enable for write port 3.
REQ-006 ra1  input  5  read address, port 1.
REQ-007 ra2  input  5  read address, port 2.
REQ-008 wa3  input  5  write address, port 3.
REQ-009 wd3  input  64  write data, port 3.
REQ-010 rd1  output  64  read data, port 1.
REQ-011 rd2  output  64  read data, port 2.
REQ-012 Port order SHALL be clk, we3, ra1, ra2, wa3, wd3, rd1, rd2, reset, so existing positional instantiations stay valid.

Function
REQ-013 Storage SHALL be registers X0..X30, each DATA_W bits; X31 SHALL be the zero register (XZR) with no storage.
REQ-014 rd1 SHALL equal X[ra1] and rd2 SHALL equal X[ra2], purely combinationally, with zero-cycle latency.
REQ-015 Reading address 31 on either port SHALL return 64'd0.
REQ-016 On a rising clk edge with reset=0, we3=1 and wa3≠31, X[wa3] SHALL be loaded with wd3.
REQ-017 A write with wa3=31, or with we3=0, SHALL change no state.
REQ-018 Write-then-read: after the writing edge, rd1/rd2 SHALL show the new value combinationally. Before that edge they SHALL show the old value; there is no write-to-read bypass.
REQ-019 Both read ports SHALL be independent and MAY address the same register simultaneously, returning identical data.
REQ-020 X/Z on ra1 or ra2 MAY produce X on the corresponding output; X on wa3 or wd3 with we3=0 SHALL NOT corrupt state.
REQ-021 Power-up (simulation initial) contents SHALL equal the reset contents (REQ-022), so reads are defined without asserting reset.

Reset
REQ-022 On a rising clk edge with reset=1, X[i] SHALL be set to i (zero-extended to 64 bits) for i=0..30.
REQ-023 Reset SHALL take priority over a simultaneous write; the write SHALL be discarded.
REQ-024 Outputs SHALL reflect the reset contents combinationally after the reset edge: rd=ra for ra<31, and 0 for ra=31.
REQ-025 Reset SHALL be asserted for one edge minimum; holding it longer SHALL keep the contents at reset values.

Structure
REQ-026 A shared package SHALL hold DATA_W, NREGS, the address width (5) and the constant ZR_ADDR=31.
REQ-027 The module SHALL have no sub-modules: one storage array, two combinational read muxes with a zero-register check, and one clocked write/reset process.

Verification
REQ-028 No reset, we3=0, ra1=ra2=i for i=0..30 -> rd1=rd2=i at each step.
REQ-029 ra1=1, ra2=0, wa3=1, wd3=2, we3=1, one edge -> rd1=2, rd2=0.
REQ-030 ra1=11, ra2=5, wa3=11, wd3=45, we3=1, one edge -> rd1=45, rd2=5.
REQ-031 we3=1, wa3=31, wd3=64'hFFFF_FFFF_FFFF_FFFF, one edge; then ra1=31 -> rd1=0, and X0..X30 unchanged.
REQ-032 X3 previously written to 99; reset=1 with we3=1, wa3=3, wd3=7, one edge -> rd1 at ra1=3 reads 3 (reset wins).
REQ-033 we3=0, wa3=4, wd3=123, one edge -> rd1 at ra1=4 reads 4 (no write).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file: data width, register count,
// address width and the zero-register address.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZR_ADDR = 5'd31;

endpackage

// File: rtl/regfile.sv
// Three-port register file: two combinational read ports, one clocked write
// port. X0..X30 hold data, X31 reads as zero and has no storage.
//
// Storage is kept XOR-encoded against the register index: the cell for Xi
// holds (Xi ^ i). An all-zero array therefore means "every register holds its
// own index", which is exactly the reset image. This lets the power-up
// contents match the reset contents through a plain zero initializer, and
// reset becomes a simple clear. Reads and writes apply the same XOR, so the
// encoding is invisible at the ports.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int NREGS  = regfile_pkg::NREGS
) (
    input  logic              clk,
    input  logic              we3,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic [4:0]        wa3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              reset
);

    logic [DATA_W-1:0] regs [0:NREGS-2] = '{default: '0};

    // Read port 1: zero register check, otherwise decode stored value.
    always_comb begin
        rd1 = '0;
        if (ra1 != ZR_ADDR) begin
            rd1 = regs[ra1] ^ DATA_W'(ra1);
        end
    end

    // Read port 2: identical, independent of port 1.
    always_comb begin
        rd2 = '0;
        if (ra2 != ZR_ADDR) begin
            rd2 = regs[ra2] ^ DATA_W'(ra2);
        end
    end

    // Write/reset: reset restores Xi = i and discards any same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (wa3 != ZR_ADDR)) begin
            regs[wa3] <= wd3 ^ DATA_W'(wa3);
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
module tb_regfile;

    logic        clk = 1'b0;
    logic        we3 = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [4:0]  wa3 = '0;
    logic [63:0] wd3 = '0;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    regfile dut (
        .clk   (clk),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read register r on port 1 and compare with v.
    task automatic rd_check(input string tag, input logic [4:0] r, input logic [63:0] v);
        ra1 = r;
        #1;
        check(tag, rd1, v);
    endtask

    initial begin
        // Power-up contents without any reset: Xi = i, X31 = 0.
        #2;
        for (int i = 0; i < 31; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            #1;
            check($sformatf("pwrup_rd1_x%0d", i), rd1, 64'(i));
            check($sformatf("pwrup_rd2_x%0d", i), rd2, 64'(i));
        end
        ra1 = 5'd31; ra2 = 5'd31;
        #1;
        check("pwrup_rd1_x31", rd1, 64'd0);
        check("pwrup_rd2_x31", rd2, 64'd0);

        // Write X1 = 2, read X1 and X0.
        ra1 = 5'd1; ra2 = 5'd0; wa3 = 5'd1; wd3 = 64'd2; we3 = 1'b1;
        #1;
        check("no_bypass_x1", rd1, 64'd1);
        tick();
        check("wr_x1_rd1", rd1, 64'd2);
        check("wr_x1_rd2", rd2, 64'd0);

        // Write X11 = 45, read X11 and X5.
        ra1 = 5'd11; ra2 = 5'd5; wa3 = 5'd11; wd3 = 64'd45;
        tick();
        check("wr_x11_rd1", rd1, 64'd45);
        check("wr_x11_rd2", rd2, 64'd5);

        // Write to XZR changes nothing.
        wa3 = 5'd31; wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        we3 = 1'b0;
        rd_check("xzr_rd", 5'd31, 64'd0);
        for (int i = 0; i < 31; i++) begin
            ra1 = 5'(i);
            #1;
            check($sformatf("xzr_keep_x%0d", i), rd1,
                  (i == 1) ? 64'd2 : (i == 11) ? 64'd45 : 64'(i));
        end

        // Both ports on the same register.
        ra1 = 5'd11; ra2 = 5'd11;
        #1;
        check("same_reg_rd1", rd1, 64'd45);
        check("same_reg_rd2", rd2, 64'd45);

        // Full-width data and a high register.
        we3 = 1'b1; wa3 = 5'd30; wd3 = 64'hDEAD_BEEF_0123_4567;
        tick();
        rd_check("wr_x30", 5'd30, 64'hDEAD_BEEF_0123_4567);

        // X3 = 99, then reset with a colliding write: reset wins.
        wa3 = 5'd3; wd3 = 64'd99;
        tick();
        rd_check("wr_x3_99", 5'd3, 64'd99);
        reset = 1'b1; wa3 = 5'd3; wd3 = 64'd7;
        tick();
        reset = 1'b0; we3 = 1'b0;
        rd_check("rst_wins_x3", 5'd3, 64'd3);
        rd_check("rst_x1", 5'd1, 64'd1);
        rd_check("rst_x11", 5'd11, 64'd11);
        rd_check("rst_x30", 5'd30, 64'd30);
        rd_check("rst_x31", 5'd31, 64'd0);

        // we3=0 does not write.
        wa3 = 5'd4; wd3 = 64'd123;
        tick();
        rd_check("no_we_x4", 5'd4, 64'd4);

        // X on wa3/wd3 with we3=0 does not corrupt state.
        wa3 = 5'bx; wd3 = 64'bx;
        tick();
        rd_check("x_addr_x4", 5'd4, 64'd4);
        rd_check("x_addr_x0", 5'd0, 64'd0);

        // Reset held two edges with write attempts keeps reset contents.
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'd500;
        tick();
        rd_check("pre_rst_x9", 5'd9, 64'd500);
        reset = 1'b1; wd3 = 64'd600;
        tick();
        tick();
        rd_check("rst_hold_x9", 5'd9, 64'd9);
        reset = 1'b0; we3 = 1'b0;
        tick();
        rd_check("post_rst_x9", 5'd9, 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
